// File: rtl/memory_unit_v2.sv
// Memory/fetch unit: PC, SP, MAR and instruction register, with ROM/RAM address generation,
// a stack window in upper RAM, sticky stack flags, and breakpoint/watchpoint channels.
module memory_unit_v2 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int ROM_AW = 15,
  parameter int OP_W   = 8,
  parameter int SP_W   = 8,
  parameter int NUM_BP = 4,
  localparam int AB    = ADDR_W / DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [DATA_W-1:0]        i_bus,
  output logic [DATA_W-1:0]        o_bus,
  output logic                     o_busDrive,
  input  logic                     i_pcInc,
  input  logic                     i_pcLoadImm,
  input  logic [AB-1:0]            i_pcByteWE,
  input  logic [AB-1:0]            i_marByteWE,
  input  logic                     i_marInc,
  input  logic                     i_spPush,
  input  logic                     i_spPop,
  input  logic                     i_instrWE,
  input  logic                     i_immToBus,
  input  logic                     i_ramToBus,
  input  logic                     i_ramWE,
  input  logic                     i_useImmAddr,
  input  logic                     i_flagClear,
  input  logic [NUM_BP*ADDR_W-1:0] i_bpAddr,
  input  logic [NUM_BP*2-1:0]      i_bpMode,
  input  logic                     i_bpClear,
  output logic [ROM_AW-1:0]        o_romAddress,
  input  logic [OP_W+ADDR_W-1:0]   i_romData,
  output logic [OP_W-1:0]          o_instrCode,
  output logic [ADDR_W:0]          o_ramAddress,
  input  logic [DATA_W-1:0]        i_ramData,
  output logic [DATA_W-1:0]        o_ramData,
  output logic                     o_ramWE,
  output logic [SP_W-1:0]          o_sp,
  output logic                     o_stackOverflow,
  output logic                     o_stackUnderflow,
  output logic [NUM_BP-1:0]        o_bpHit,
  output logic                     o_halt
);

  logic [ADDR_W-1:0]        pc, mar, imm, la;
  logic [OP_W-1:0]          opcode;
  logic [SP_W-1:0]          sp;
  logic                     overflow, underflow, skip;
  logic [NUM_BP-1:0]        hit, accessMatch, execMatch, hitSet;
  logic [ADDR_W-DATA_W-1:0] spExt;
  logic                     stk, halt, anyExec, pcEnable, instrAccept;

  assign la  = i_useImmAddr ? imm : mar;
  assign stk = &la[ADDR_W-1:DATA_W];

  always_comb begin
    spExt = '0;
    spExt[SP_W-1:0] = sp;
    o_ramAddress = stk ? {1'b1, spExt, la[DATA_W-1:0]} : {1'b0, la};
  end

  always_comb begin
    accessMatch = '0;
    execMatch   = '0;
    for (int n = 0; n < NUM_BP; n++) begin
      case (i_bpMode[2*n +: 2])
        2'b01:   execMatch[n]   = i_instrWE && !skip && (pc == i_bpAddr[n*ADDR_W +: ADDR_W]);
        2'b10:   accessMatch[n] = i_ramToBus && (la == i_bpAddr[n*ADDR_W +: ADDR_W]);
        2'b11:   accessMatch[n] = i_ramWE && (la == i_bpAddr[n*ADDR_W +: ADDR_W]);
        default: ;
      endcase
    end
  end

  // An exec hit suppresses the fetch it matched so the halted PC points at the breakpoint.
  assign hitSet      = accessMatch | execMatch;
  assign halt        = |hit;
  assign anyExec     = |execMatch;
  assign pcEnable    = !halt && !anyExec;
  assign instrAccept = i_instrWE && pcEnable;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc     <= '0;
      mar    <= '0;
      opcode <= '0;
      imm    <= '0;
    end else begin
      if (pcEnable) begin
        if (i_pcLoadImm) begin
          pc <= imm;
        end else if (|i_pcByteWE) begin
          for (int k = 0; k < AB; k++)
            if (i_pcByteWE[k]) pc[k*DATA_W +: DATA_W] <= i_bus;
        end else if (i_pcInc) begin
          pc <= pc + 1'b1;
        end
      end
      if (|i_marByteWE) begin
        for (int k = 0; k < AB; k++)
          if (i_marByteWE[k]) mar[k*DATA_W +: DATA_W] <= i_bus;
      end else if (i_marInc) begin
        mar <= mar + 1'b1;
      end
      if (instrAccept) {opcode, imm} <= i_romData;
    end
  end

  // Stack pointer wraps in both directions; flags latch until cleared, and a fresh set beats the clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (i_spPush && !i_spPop) sp <= sp + 1'b1;
      else if (i_spPop && !i_spPush) sp <= sp - 1'b1;
      if (i_spPush && !i_spPop && (&sp)) overflow <= 1'b1;
      else if (i_flagClear) overflow <= 1'b0;
      if (i_spPop && !i_spPush && (sp == '0)) underflow <= 1'b1;
      else if (i_flagClear) underflow <= 1'b0;
    end
  end

  // Clearing arms skip so resuming on an exec breakpoint fetches past it once.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hit  <= '0;
      skip <= 1'b0;
    end else begin
      hit <= (i_bpClear ? '0 : hit) | hitSet;
      if (i_bpClear) skip <= 1'b1;
      else if (instrAccept) skip <= 1'b0;
    end
  end

  assign o_busDrive       = i_immToBus | i_ramToBus;
  assign o_bus            = i_ramToBus ? i_ramData : (i_immToBus ? imm[DATA_W-1:0] : '0);
  assign o_romAddress     = pc[ROM_AW-1:0];
  assign o_instrCode      = opcode;
  assign o_ramData        = i_bus;
  assign o_ramWE          = i_ramWE;
  assign o_sp             = sp;
  assign o_stackOverflow  = overflow;
  assign o_stackUnderflow = underflow;
  assign o_bpHit          = hit;
  assign o_halt           = halt;

endmodule

// File: tb/tb_memory_unit_v2.sv
// Directed testbench for memory_unit_v2 with default parameters; expected values computed by hand.
module tb_memory_unit_v2;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_bus, o_bus, i_ramData, o_ramData;
  logic        o_busDrive, i_pcInc, i_pcLoadImm, i_marInc, i_spPush, i_spPop;
  logic [1:0]  i_pcByteWE, i_marByteWE;
  logic        i_instrWE, i_immToBus, i_ramToBus, i_ramWE, i_useImmAddr, i_flagClear, i_bpClear;
  logic [63:0] i_bpAddr;
  logic [7:0]  i_bpMode;
  logic [14:0] o_romAddress;
  logic [23:0] i_romData, romValue;
  logic        useRomModel;
  logic [7:0]  o_instrCode, o_sp;
  logic [16:0] o_ramAddress;
  logic        o_ramWE, o_stackOverflow, o_stackUnderflow, o_halt;
  logic [3:0]  o_bpHit;
  int          checks = 0;
  int          errors = 0;

  memory_unit_v2 dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_bus(i_bus), .o_bus(o_bus), .o_busDrive(o_busDrive),
    .i_pcInc(i_pcInc), .i_pcLoadImm(i_pcLoadImm), .i_pcByteWE(i_pcByteWE),
    .i_marByteWE(i_marByteWE), .i_marInc(i_marInc), .i_spPush(i_spPush), .i_spPop(i_spPop),
    .i_instrWE(i_instrWE), .i_immToBus(i_immToBus), .i_ramToBus(i_ramToBus), .i_ramWE(i_ramWE),
    .i_useImmAddr(i_useImmAddr), .i_flagClear(i_flagClear), .i_bpAddr(i_bpAddr),
    .i_bpMode(i_bpMode), .i_bpClear(i_bpClear), .o_romAddress(o_romAddress),
    .i_romData(i_romData), .o_instrCode(o_instrCode), .o_ramAddress(o_ramAddress),
    .i_ramData(i_ramData), .o_ramData(o_ramData), .o_ramWE(o_ramWE), .o_sp(o_sp),
    .o_stackOverflow(o_stackOverflow), .o_stackUnderflow(o_stackUnderflow),
    .o_bpHit(o_bpHit), .o_halt(o_halt)
  );

  always #5 i_clk = ~i_clk;

  // ROM model: opcode = addr^0xA5, immediate = 0x01xx with xx the low address byte.
  always_comb begin
    if (useRomModel) i_romData = {o_romAddress[7:0] ^ 8'hA5, 8'h01, o_romAddress[7:0]};
    else             i_romData = romValue;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clearInputs();
    i_bus = '0; i_pcInc = 0; i_pcLoadImm = 0; i_pcByteWE = '0; i_marByteWE = '0;
    i_marInc = 0; i_spPush = 0; i_spPop = 0; i_instrWE = 0; i_immToBus = 0;
    i_ramToBus = 0; i_ramWE = 0; i_useImmAddr = 0; i_flagClear = 0; i_bpClear = 0;
    i_ramData = '0;
  endtask

  task automatic doReset();
    clearInputs();
    i_reset = 1;
    applyStimulus();
    applyStimulus();
    i_reset = 0;
  endtask

  initial begin
    i_bpAddr = '0; i_bpMode = '0; useRomModel = 1; romValue = '0;
    doReset();
    checkOutput("rstRom", o_romAddress, 0);
    checkOutput("rstSp", o_sp, 0);
    checkOutput("rstFlags", {o_stackOverflow, o_stackUnderflow}, 0);
    checkOutput("rstHit", {o_halt, o_bpHit}, 0);
    checkOutput("rstOpcode", o_instrCode, 0);
    checkOutput("rstRamAddr", o_ramAddress, 0);
    checkOutput("rstBus", {o_busDrive, o_bus}, 0);

    // PC byte loads
    i_pcByteWE = 2'b10; i_bus = 8'h12; applyStimulus();
    i_pcByteWE = 2'b01; i_bus = 8'h34; applyStimulus();
    clearInputs();
    checkOutput("pcBytes", o_romAddress, 15'h1234);

    // MAR, stack window and RAM passthrough
    i_marByteWE = 2'b10; i_bus = 8'hFF; applyStimulus();
    i_marByteWE = 2'b01; i_bus = 8'h05; applyStimulus();
    clearInputs();
    i_spPush = 1;
    for (int i = 0; i < 7; i++) applyStimulus();
    clearInputs();
    checkOutput("spSeven", o_sp, 8'h07);
    checkOutput("stackWin", o_ramAddress, 17'h10705);
    i_marByteWE = 2'b10; i_bus = 8'h12; applyStimulus();
    clearInputs();
    checkOutput("plainAddr", o_ramAddress, 17'h01205);
    i_marByteWE = 2'b11; i_bus = 8'hFF; applyStimulus();
    clearInputs();
    checkOutput("marFFFF", o_ramAddress, {1'b1, 8'h07, 8'hFF});
    i_marInc = 1; i_marByteWE = 2'b00; applyStimulus();
    clearInputs();
    checkOutput("marWrap", o_ramAddress, 0);
    i_ramWE = 1; i_bus = 8'h5A; #1;
    checkOutput("ramPass", {o_ramWE, o_ramData}, {1'b1, 8'h5A});
    clearInputs();

    // Stack pointer and flags
    doReset();
    i_spPop = 1; applyStimulus();
    clearInputs();
    checkOutput("popZero", {o_sp, o_stackOverflow, o_stackUnderflow}, {8'hFF, 2'b01});
    i_spPush = 1;
    for (int i = 0; i < 255; i++) applyStimulus();
    clearInputs();
    checkOutput("push255", {o_sp, o_stackOverflow}, {8'hFE, 1'b1});
    i_spPush = 1; i_spPop = 1; applyStimulus();
    clearInputs();
    checkOutput("pushPop", o_sp, 8'hFE);
    i_spPush = 1; applyStimulus(); applyStimulus();
    clearInputs();
    checkOutput("pushWrap", {o_sp, o_stackOverflow}, {8'h00, 1'b1});
    i_flagClear = 1; applyStimulus();
    clearInputs();
    checkOutput("flagClear", {o_stackOverflow, o_stackUnderflow}, 0);
    i_spPop = 1; i_flagClear = 1; applyStimulus();
    clearInputs();
    checkOutput("setBeatsClr", {o_sp, o_stackOverflow, o_stackUnderflow}, {8'hFF, 2'b01});

    // Exec breakpoint on channel 0 at 0x0003
    doReset();
    i_bpMode = 8'b0000_0001; i_bpAddr[15:0] = 16'h0003;
    i_instrWE = 1; i_pcInc = 1;
    for (int i = 0; i < 5; i++) applyStimulus();
    clearInputs();
    checkOutput("execOpcode", o_instrCode, 8'hA7);
    checkOutput("execPc", o_romAddress, 15'h0003);
    checkOutput("execHit", {o_halt, o_bpHit}, 5'b1_0001);
    i_immToBus = 1; #1;
    checkOutput("execImm", o_bus, 8'h02);
    clearInputs();
    i_bpClear = 1; applyStimulus();
    clearInputs();
    checkOutput("execClear", {o_halt, o_bpHit}, 0);
    i_instrWE = 1; i_pcInc = 1; applyStimulus();
    clearInputs();
    checkOutput("resumeOp", o_instrCode, 8'hA6);
    checkOutput("resumePc", o_romAddress, 15'h0004);
    checkOutput("noRehit", o_bpHit, 0);
    i_pcByteWE = 2'b01; i_bus = 8'h03; applyStimulus();
    clearInputs();
    i_instrWE = 1; i_pcInc = 1; applyStimulus();
    clearInputs();
    checkOutput("skipGone", {o_halt, o_bpHit, o_romAddress}, {5'b1_0001, 15'h0003});
    i_bpMode = '0; i_bpClear = 1; applyStimulus();
    clearInputs();

    // Write watchpoint on channel 2, read watchpoint on channel 1
    doReset();
    useRomModel = 0; romValue = 24'h33_4000;
    i_instrWE = 1; applyStimulus();
    clearInputs();
    checkOutput("loadImm", o_instrCode, 8'h33);
    i_bpMode = 8'b0011_0000; i_bpAddr[47:32] = 16'h4000;
    i_useImmAddr = 1; i_ramWE = 1; i_bus = 8'h77; #1;
    checkOutput("wrAddr", {o_ramWE, o_ramAddress}, {1'b1, 17'h04000});
    applyStimulus();
    clearInputs();
    checkOutput("wrHit", {o_halt, o_bpHit}, 5'b1_0100);
    romValue = 24'h55_1111;
    i_pcInc = 1; i_instrWE = 1; applyStimulus();
    clearInputs();
    checkOutput("haltPc", o_romAddress, 0);
    checkOutput("haltInstr", o_instrCode, 8'h33);
    i_marInc = 1; i_spPush = 1; applyStimulus();
    clearInputs();
    checkOutput("haltMar", o_ramAddress, 17'h00001);
    checkOutput("haltSp", o_sp, 8'h01);
    i_marByteWE = 2'b10; i_bus = 8'hFF; applyStimulus();
    i_marByteWE = 2'b01; i_bus = 8'h10; applyStimulus();
    clearInputs();
    i_bpMode = 8'b0011_1000; i_bpAddr[31:16] = 16'hFF10;
    i_ramToBus = 1; i_ramData = 8'hC3; i_bpClear = 1; #1;
    checkOutput("rdBus", {o_busDrive, o_bus, o_ramAddress}, {1'b1, 8'hC3, 17'h10110});
    applyStimulus();
    clearInputs();
    checkOutput("rdHit", {o_halt, o_bpHit}, 5'b1_0010);
    i_bpClear = 1; applyStimulus();
    clearInputs();
    checkOutput("rdClear", o_bpHit, 0);
    i_pcInc = 1; applyStimulus();
    clearInputs();
    checkOutput("resumeInc", o_romAddress, 15'h0001);

    // PC update priority and bus selection
    i_bpMode = '0; romValue = 24'h5E_BEEF;
    i_instrWE = 1; applyStimulus();
    clearInputs();
    i_useImmAddr = 1; #1;
    checkOutput("immAddr", o_ramAddress, 17'h0BEEF);
    clearInputs();
    i_pcLoadImm = 1; i_pcByteWE = 2'b11; i_bus = 8'h00; i_pcInc = 1; applyStimulus();
    clearInputs();
    checkOutput("loadPrio", o_romAddress, 15'h3EEF);
    i_pcByteWE = 2'b01; i_bus = 8'h10; i_pcInc = 1; applyStimulus();
    clearInputs();
    checkOutput("bytePrio", o_romAddress, 15'h3E10);
    i_immToBus = 1; i_ramToBus = 1; i_ramData = 8'h9C; #1;
    checkOutput("ramWinsBus", {o_busDrive, o_bus}, {1'b1, 8'h9C});
    i_ramToBus = 0; #1;
    checkOutput("immBus", {o_busDrive, o_bus}, {1'b1, 8'hEF});
    clearInputs(); #1;
    checkOutput("idleBus", {o_busDrive, o_bus}, 0);
    romValue = 24'h00_FF42;
    i_instrWE = 1; applyStimulus();
    clearInputs();
    i_useImmAddr = 1; #1;
    checkOutput("immStack", o_ramAddress, 17'h10142);
    clearInputs();

    // Reset overrides concurrent updates
    i_reset = 1; i_pcInc = 1; i_spPush = 1; applyStimulus();
    clearInputs();
    i_reset = 0;
    checkOutput("rstOverride", {o_romAddress, o_sp}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_unit_v2.md
Name: memory_unit_v2

Overview:
- Parametrised memory/fetch unit for the CPU datapath.
- Holds PC, SP, MAR and the instruction register (opcode + immediate). Drives ROM and RAM addresses, with a stack window mapped into the upper RAM half.
- Over the 8-bit predecessor it adds: generic widths, MAR auto-increment, sticky stack overflow/underflow flags, and NUM_BP breakpoint/watchpoint channels with halt and single-step re-arm.

Parameters:
DATA_W, 8, bus/byte width
ADDR_W, 16, logical address width (PC, MAR, immediate); must be a multiple of DATA_W; AB = ADDR_W/DATA_W
ROM_AW, 15, ROM address width (<= ADDR_W)
OP_W, 8, opcode width
SP_W, 8, stack pointer width (<= ADDR_W-DATA_W)
NUM_BP, 4, breakpoint channels (1..8)

Ports:
i_clk  in  1  clock
i_reset  in  1  reset
i_bus  in  DATA_W  data bus input
o_bus  out  DATA_W  data bus output
o_busDrive  out  1  o_bus valid
i_pcInc  in  1  PC += 1
i_pcLoadImm  in  1  PC <= immediate
i_pcByteWE  in  AB  PC byte k <= i_bus
i_marByteWE  in  AB  MAR byte k <= i_bus
i_marInc  in  1  MAR += 1
i_spPush  in  1  SP += 1
i_spPop  in  1  SP -= 1
i_instrWE  in  1  latch i_romData
i_immToBus  in  1  imm low byte to bus
i_ramToBus  in  1  RAM data to bus
i_ramWE  in  1  RAM write strobe
i_useImmAddr  in  1  1: RAM address from immediate, 0: from MAR
i_flagClear  in  1  clear stack flags
i_bpAddr  in  NUM_BP*ADDR_W  per-channel compare address
i_bpMode  in  NUM_BP*2  00 off, 01 exec, 10 read, 11 write
i_bpClear  in  1  clear hits, arm skip
o_romAddress  out  ROM_AW  PC[ROM_AW-1:0]
i_romData  in  OP_W+ADDR_W  {opcode, immediate}
o_instrCode  out  OP_W  opcode register
o_ramAddress  out  ADDR_W+1  physical RAM address
i_ramData  in  DATA_W  RAM read data
o_ramData  out  DATA_W  = i_bus
o_ramWE  out  1  = i_ramWE
o_sp  out  SP_W  stack pointer
o_stackOverflow  out  1  sticky
o_stackUnderflow  out  1  sticky
o_bpHit  out  NUM_BP  sticky per-channel hit
o_halt  out  1  = |o_bpHit

Behaviour:
- Clock and reset: all state on posedge i_clk. Reset is i_reset, synchronous, active-high, and overrides every other input.
- Reset values: PC, SP, MAR, opcode, immediate, flags, hits and skip all 0.
- Logical address LA = i_useImmAddr ? imm : MAR.
- Stack select: STK = (LA[ADDR_W-1:DATA_W] all ones).
  - STK=1: o_ramAddress = {1, zero-extended SP, LA[DATA_W-1:0]}.
  - STK=0: o_ramAddress = {0, LA}.
  - Combinational.
- PC update (only when o_halt=0):
  - Priority i_pcLoadImm > i_pcByteWE (per byte, multiple bytes allowed) > i_pcInc.
  - Increment wraps at 2^ADDR_W.
- MAR update: i_marByteWE bytes win over i_marInc; increment is full-width with wrap. Not gated by halt.
- SP update:
  - Push alone: +1. Pop alone: -1. Both: no change.
  - Push at all-ones wraps to 0 and sets o_stackOverflow.
  - Pop at 0 wraps to all-ones and sets o_stackUnderflow.
  - Flags are sticky; a new set wins over i_flagClear in the same cycle.
- Instruction latch: when i_instrWE=1, o_halt=0 and no exec hit this cycle, {opcode, imm} <= i_romData.
- Bus output:
  - o_busDrive = i_immToBus | i_ramToBus.
  - o_bus = i_ramToBus ? i_ramData : imm[DATA_W-1:0] (RAM wins if both asserted).
  - o_bus = 0 when not driven.
- Breakpoint channel n, combinational match:
  - exec: i_instrWE & PC==bpAddr & ~skip.
  - read: i_ramToBus & LA==bpAddr.
  - write: i_ramWE & LA==bpAddr.
- Hit handling:
  - A match sets o_bpHit[n] at the next edge.
  - An exec match also suppresses that cycle's instruction latch and PC update.
- Halt scope: o_halt blocks PC and instruction updates only. RAM, MAR and SP stay operational so a debugger can inspect state.
- i_bpClear: clears all hits and sets skip. A match in the same cycle still sets its hit (set wins). Skip clears on the next accepted i_instrWE.

Test Plan:
- Reset then i_pcByteWE=2'b10 with bus 0x12, next cycle 2'b01 with bus 0x34 -> PC=0x1234, o_romAddress=0x1234.
- MAR=0xFF05, SP=0x07, i_useImmAddr=0 -> o_ramAddress=0x10705; MAR=0x1205 -> 0x01205; i_marInc at 0xFFFF -> MAR=0x0000.
- Reset, i_spPop -> SP=0xFF, o_stackUnderflow=1; 255 pushes -> SP=0xFE; two more -> SP=0x00, o_stackOverflow=1; i_flagClear -> both flags 0.
- Channel 0 exec at 0x0003, fetch with pcInc each cycle from 0 -> opcode of 0x0002 retained, PC holds 0x0003, o_bpHit=0001, o_halt=1; i_bpClear then fetch -> 0x0003 latched, PC=0x0004, no re-hit.
- Channel 2 write at 0x4000, imm=0x4000, i_useImmAddr=1, i_ramWE -> o_bpHit[2]=1, o_ramWE still 1, PC frozen; i_pcInc ignored until clear.
- i_pcLoadImm, i_pcByteWE and i_pcInc together with imm=0xBEEF -> PC=0xBEEF; i_immToBus and i_ramToBus together -> o_bus=i_ramData.
